// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-skip adder: stage-count helper and operation encoding.
package csa_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } csa_op_e;

    function automatic int csa_nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: BLOCK-bit ripple adder with a propagate-AND skip mux on the carry-out.
module csa_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             skip,
    output logic             msb_cin
);

    logic [BLOCK:0]   c;
    logic [BLOCK-1:0] p;

    // NOTE: every variable written in always_comb gets a value before any branch or loop,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        c    = '0;
        sum  = '0;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i]   = p[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & p[i]);
        end
    end

    assign skip    = &p;
    assign cout    = skip ? cin : c[BLOCK];
    assign msb_cin = c[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder/subtractor: one skip block per stage, global valid/ready stall.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int BLOCK = 4,
    localparam int NBLK  = csa_nblk(WIDTH, BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [NBLK-1:0]  out_skip
);

    if (BLOCK < 1 || WIDTH < 2 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK and at least 2");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             msb_cin;
        logic [NBLK-1:0]  skip;
    } stage_t;

    stage_t     st_q [NBLK];
    stage_t     st_d [NBLK];
    stage_t     src  [NBLK];
    logic [BLOCK-1:0] blk_a   [NBLK];
    logic [BLOCK-1:0] blk_b   [NBLK];
    logic [BLOCK-1:0] blk_sum [NBLK];
    logic       blk_cin     [NBLK];
    logic       blk_cout    [NBLK];
    logic       blk_skip    [NBLK];
    logic       blk_msb_cin [NBLK];
    logic       adv;
    csa_op_e    op;

    assign op       = csa_op_e'(in_sub);
    assign adv      = !st_q[NBLK-1].valid || out_ready;
    assign in_ready = adv && !rst;

    // Stage 0 takes the operands straight from the ports; subtract is folded in here.
    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].a_rem = in_a;
        src[0].b_rem = (op == OP_SUB) ? ~in_b : in_b;
        src[0].carry = (op == OP_SUB) ? 1'b1 : in_cin;
        for (int k = 1; k < NBLK; k++) begin
            src[k] = st_q[k-1];
        end
        for (int k = 0; k < NBLK; k++) begin
            blk_a[k]   = src[k].a_rem[BLOCK-1:0];
            blk_b[k]   = src[k].b_rem[BLOCK-1:0];
            blk_cin[k] = src[k].carry;
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        csa_skip_block #(.BLOCK(BLOCK)) u_blk (
            .a       (blk_a[k]),
            .b       (blk_b[k]),
            .cin     (blk_cin[k]),
            .sum     (blk_sum[k]),
            .cout    (blk_cout[k]),
            .skip    (blk_skip[k]),
            .msb_cin (blk_msb_cin[k])
        );
    end

    // Operand remainders shift down so each stage always consumes the low BLOCK bits.
    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            st_d[k]                        = src[k];
            st_d[k].a_rem                  = src[k].a_rem >> BLOCK;
            st_d[k].b_rem                  = src[k].b_rem >> BLOCK;
            st_d[k].sum[k*BLOCK +: BLOCK]  = blk_sum[k];
            st_d[k].carry                  = blk_cout[k];
            st_d[k].msb_cin                = blk_msb_cin[k];
            st_d[k].skip[k]                = blk_skip[k];
        end
    end

    // NOTE: the pipeline is shallow, so the data fields are reset along with the valids;
    // that keeps every output at a defined zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
            for (int k = 0; k < NBLK; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign out_valid = st_q[NBLK-1].valid;
    assign out_sum   = st_q[NBLK-1].sum;
    assign out_cout  = st_q[NBLK-1].carry;
    assign out_ovf   = st_q[NBLK-1].msb_cin ^ st_q[NBLK-1].carry;
    assign out_skip  = st_q[NBLK-1].skip;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder (WIDTH=16, BLOCK=4): directed vectors, stall, reset, random traffic.
module tb_csa_pipe_adder;

    localparam int LAT_EDGES = 3;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  skip;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [3:0]  out_skip;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t exp_q[$];
    vec_t dir[10];

    csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_skip  (out_skip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        vec_t        v;
        logic [15:0] bb;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        bb     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
        low    = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + {15'd0, c0};
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sub  = sub;
        v.sum  = full[15:0];
        v.cout = full[16];
        v.ovf  = low[15] ^ full[16];
        for (int k = 0; k < 4; k++) v.skip[k] = &(a[4*k +: 4] ^ bb[4*k +: 4]);
        return v;
    endfunction

    task automatic send(input vec_t v, input bit rand_rdy);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_sub   = v.sub;
        forever begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v);
                step();
                break;
            end
            step();
            n++;
            if (n > 200) begin
                check("send_timeout", n, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic latency_check(input vec_t v);
        int n;
        send(v, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("latency_edges", n, LAT_EDGES);
        wait_drain();
    endtask

    // Monitor: compares the DUT output with the queue head every cycle it is valid,
    // which also checks that a stalled result is held steady.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sum 0x%0h, expected no result", out_sum);
                end else begin
                    e = exp_q[0];
                    check("out_sum",  32'(out_sum),  32'(e.sum));
                    check("out_cout", 32'(out_cout), 32'(e.cout));
                    check("out_ovf",  32'(out_ovf),  32'(e.ovf));
                    check("out_skip", 32'(out_skip), 32'(e.skip));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int idx;
        int seen;
        vec_t burst[8];

        dir[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        dir[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110};
        dir[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b1110};
        dir[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0110};
        dir[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
        dir[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 4'b0000};
        dir[6] = '{16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111};
        dir[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
        dir[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
        dir[9] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 4'b1100};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready",  32'(in_ready),  0);
        check("reset_out_sum",   32'(out_sum),   0);
        check("reset_out_flags", 32'({out_cout, out_ovf, out_skip}), 0);
        rst = 1'b0;
        step();
        check("idle_in_ready", 32'(in_ready), 1);

        // Directed vectors one at a time; first one also measures latency.
        latency_check(dir[0]);
        for (int i = 1; i < 4; i++) begin
            send(dir[i], 1'b0);
            wait_drain();
        end

        // Eight back-to-back beats with out_ready low in cycles 5-7.
        for (int i = 0; i < 8; i++) burst[i] = dir[i + 2];
        idx = 0;
        for (int cyc = 0; cyc < 60 && (idx < 8 || exp_q.size() > 0); cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (idx < 8) begin
                in_valid = 1'b1;
                in_a     = burst[idx].a;
                in_b     = burst[idx].b;
                in_cin   = burst[idx].cin;
                in_sub   = burst[idx].sub;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 5 && cyc <= 7) begin
                check("stall_out_valid", 32'(out_valid), 1);
                check("stall_in_ready",  32'(in_ready),  0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(burst[idx]);
                idx++;
            end
            if (cyc == 10) check("burst_accepts_after_stall", idx, 8);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("burst_all_accepted", idx, 8);
        wait_drain();

        // Reset with three beats in flight, the oldest already presented and stalled.
        send(dir[4], 1'b0);
        send(dir[5], 1'b0);
        send(dir[6], 1'b0);
        out_ready = 1'b0;
        step();
        check("pre_reset_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 0);
        check("mid_reset_in_ready",  32'(in_ready),  0);
        check("mid_reset_out_sum",   32'(out_sum),   0);
        exp_q.delete();
        step();
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        seen      = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_reset_no_results", seen, 0);
        @(posedge clk);
        #1;
        latency_check(dir[7]);
        send(dir[8], 1'b0);
        send(dir[9], 1'b0);
        wait_drain();

        // Random operands and random back-pressure against the reference model.
        for (int i = 0; i < 150; i++) begin
            send(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 1'b1);
        end
        out_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
